// File: rtl/audio_peak_hold.sv
// -----------------------------------------------------------------------------
// audio_peak_hold
//
// Per-channel peak meter feeding the LED bar driver. Every accepted sample is
// turned into a bar index (one segment per 6 dB, i.e. one bit of magnitude),
// the per-frame maximum is tracked per channel, and at each frame end a
// peak-hold / one-segment-per-frame decay law updates the displayed level.
// One left/right level pair is offered per frame on a valid/ready output.
//
// Ports
//   clk            sample-domain clock
//   nreset         asynchronous active-low reset
//   i_valid        input sample valid
//   i_ready        input ready (always 1 out of reset; never backpressures)
//   i_is_left      1 = left sample, 0 = right sample
//   i_audio        signed sample, MSB-aligned
//   o_valid        level pair valid
//   o_ready        downstream ready
//   o_level_left   left bar level, 0..LEVELS
//   o_level_right  right bar level, 0..LEVELS
//   o_overrun      sticky: a frame result replaced an unconsumed one
// -----------------------------------------------------------------------------
module audio_peak_hold #(
  parameter  int LEVELS         = 16,
  parameter  int UPDATE_SAMPLES = 1024,
  parameter  int HOLD_FRAMES    = 8,
  localparam int LW             = $clog2(LEVELS + 1)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic          i_is_left,
  input  logic [31:0]   i_audio,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [LW-1:0] o_level_left,
  output logic [LW-1:0] o_level_right,
  output logic          o_overrun
);

  localparam int CW = (UPDATE_SAMPLES > 1) ? $clog2(UPDATE_SAMPLES) : 1;
  localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  typedef struct packed {
    logic [LW-1:0] disp;
    logic [HW-1:0] hold;
  } chan_t;

  // ---------------------------------------------------------------------------
  // Magnitude window. Only bits 30 .. 31-LEVELS of |x| matter. For negative x,
  // -x = ~(x - 1); the borrow out of the bits below the window is simply
  // "all low bits are zero", so the full 32-bit negation is never built.
  // A zero bit is appended so the low slice is never empty (LEVELS = 31).
  // ---------------------------------------------------------------------------
  logic [32:0]       audio_ext;
  logic [LEVELS-1:0] raw_win;
  logic [LEVELS-1:0] abs_win;
  logic              low_zero;
  logic [LW-1:0]     level;

  assign audio_ext = {i_audio, 1'b0};
  assign raw_win   = audio_ext[31:32-LEVELS];
  assign low_zero  = (audio_ext[31-LEVELS:0] == '0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    abs_win = raw_win;
    if (audio_ext[32]) begin
      if (raw_win == '0 && low_zero) begin
        abs_win = '1;                                 // -2^31 saturates to 2^31-1
      end else begin
        abs_win = ~(raw_win - LEVELS'(low_zero));
      end
    end
  end

  // Highest set window bit wins: position k maps to level k+1.
  always_comb begin
    level = '0;
    for (int k = 0; k < LEVELS; k++) begin
      if (abs_win[k]) level = LW'(k + 1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame accumulation
  // ---------------------------------------------------------------------------
  logic          accept;
  logic          frame_end;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] fmax_l_q, fmax_l_d, fmax_r_q, fmax_r_d;
  logic [LW-1:0] fm_l, fm_r;

  assign i_ready   = nreset;
  assign accept    = i_valid & i_ready;
  assign frame_end = accept & ~i_is_left & (cnt_q == CW'(UPDATE_SAMPLES - 1));

  // Frame maxima including the current sample, so the frame-end sample counts.
  assign fm_l = (accept &  i_is_left & (level > fmax_l_q)) ? level : fmax_l_q;
  assign fm_r = (accept & ~i_is_left & (level > fmax_r_q)) ? level : fmax_r_q;

  always_comb begin
    cnt_d    = cnt_q;
    fmax_l_d = frame_end ? '0 : fm_l;
    fmax_r_d = frame_end ? '0 : fm_r;
    if (accept && !i_is_left) begin
      cnt_d = frame_end ? '0 : cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Peak hold and decay, evaluated once per frame per channel
  // ---------------------------------------------------------------------------
  function automatic chan_t frame_update(input chan_t cur, input logic [LW-1:0] fm);
    chan_t nxt;
    nxt = cur;
    if (fm >= cur.disp) begin
      nxt.disp = fm;
      nxt.hold = HW'(HOLD_FRAMES);
    end else if (cur.hold != '0) begin
      nxt.hold = cur.hold - 1'b1;
    end else begin
      // fm < disp here, so disp >= 1 and the decrement cannot wrap.
      nxt.disp = ((cur.disp - 1'b1) > fm) ? cur.disp - 1'b1 : fm;
    end
    return nxt;
  endfunction

  chan_t left_q, left_d, right_q, right_d;
  logic  valid_q, valid_d;
  logic  overrun_q, overrun_d;

  always_comb begin
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (frame_end) begin
      left_d  = frame_update(left_q, fm_l);
      right_d = frame_update(right_q, fm_r);
      valid_d = 1'b1;
      // Replacing an item that is not being consumed on this edge is an overrun.
      if (valid_q && !o_ready) overrun_d = 1'b1;
    end else if (valid_q && o_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q     <= '0;
      fmax_l_q  <= '0;
      fmax_r_q  <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values; blocking ones here would make results depend on statement order.
      cnt_q     <= cnt_d;
      fmax_l_q  <= fmax_l_d;
      fmax_r_q  <= fmax_r_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Displayed levels only change at a frame end, so they are stable while the
  // pair is pending and can drive the outputs directly.
  assign o_valid       = valid_q;
  assign o_level_left  = left_q.disp;
  assign o_level_right = right_q.disp;
  assign o_overrun     = overrun_q;

endmodule
